// File: rtl/wb_result_writer_if.sv
// rtl/wb_result_writer_if.sv - writeback request/response bundle between the control FSM and the result writer (trap signal only with WB_MISALIGN_TRAP_EN)
interface wb_result_writer_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  // request side, driven by the control FSM / datapath
  logic               start;
  logic [1:0]         wb_sel;
  logic [2:0]         funct3;
  logic [RADDR_W-1:0] rd;
  logic [XLEN-1:0]    alu_out;
  logic [XLEN-1:0]    mem_rdata;
  logic [XLEN-1:0]    pc_plus4;
  logic [XLEN-1:0]    imm;

  // response side, driven by the writer
  logic               rf_we;
  logic [RADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0]    rf_wdata;
  logic               busy;
  logic               done;
`ifdef WB_MISALIGN_TRAP_EN
  logic               trap;

  modport master (
    output start, wb_sel, funct3, rd, alu_out, mem_rdata, pc_plus4, imm,
    input  rf_we, rf_waddr, rf_wdata, busy, done, trap
  );

  modport slave (
    input  start, wb_sel, funct3, rd, alu_out, mem_rdata, pc_plus4, imm,
    output rf_we, rf_waddr, rf_wdata, busy, done, trap
  );
`else
  modport master (
    output start, wb_sel, funct3, rd, alu_out, mem_rdata, pc_plus4, imm,
    input  rf_we, rf_waddr, rf_wdata, busy, done
  );

  modport slave (
    input  start, wb_sel, funct3, rd, alu_out, mem_rdata, pc_plus4, imm,
    output rf_we, rf_waddr, rf_wdata, busy, done
  );
`endif
endinterface

// File: rtl/wb_result_writer.sv
// rtl/wb_result_writer.sv - 3-state register-file writeback sequencer with load align/extend; WB_MISALIGN_TRAP_EN adds a misaligned-load trap
module wb_result_writer #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  wb_result_writer_if.slave wb
);

`ifdef WB_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_IDLE, S_FORMAT, S_WRITE, S_TRAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FORMAT, S_WRITE} state_t;
`endif

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_PC4  = 2'd2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  state_t             state_q;
  logic [1:0]         sel_q;
  logic [2:0]         f3_q;
  logic [RADDR_W-1:0] rd_q;
  logic [1:0]         off_q;
  logic [XLEN-1:0]    src_q;

  logic               rf_we_q;
  logic [RADDR_W-1:0] rf_waddr_q;
  logic [XLEN-1:0]    rf_wdata_q;
  logic               busy_q;
  logic               done_q;

  logic [XLEN-1:0]    byte_sh;
  logic [XLEN-1:0]    half_sh;
  logic [XLEN-1:0]    fmt_d;
`ifdef WB_MISALIGN_TRAP_EN
  logic               trap_q;
  logic               misalign_d;
`endif

  // Format the latched source: loads are shifted down by the byte offset and
  // extended; everything else passes through untouched.
  always_comb begin
    byte_sh = src_q >> {off_q, 3'b000};
    half_sh = src_q >> {off_q[1], 4'b0000};
    fmt_d   = src_q;
    if (sel_q == SEL_LOAD) begin
      case (f3_q)
        F3_LB:   fmt_d = {{(XLEN-8){byte_sh[7]}}, byte_sh[7:0]};
        F3_LBU:  fmt_d = {{(XLEN-8){1'b0}}, byte_sh[7:0]};
        F3_LH:   fmt_d = {{(XLEN-16){half_sh[15]}}, half_sh[15:0]};
        F3_LHU:  fmt_d = {{(XLEN-16){1'b0}}, half_sh[15:0]};
        default: fmt_d = src_q;
      endcase
    end
  end

`ifdef WB_MISALIGN_TRAP_EN
  // Halfword loads need an even offset; word loads (and undefined funct3,
  // which behaves as LW) need offset 0.
  always_comb begin
    misalign_d = 1'b0;
    if (sel_q == SEL_LOAD) begin
      case (f3_q)
        F3_LB, F3_LBU: misalign_d = 1'b0;
        F3_LH, F3_LHU: misalign_d = off_q[0];
        default:       misalign_d = (off_q != 2'b00);
      endcase
    end
  end
`endif

  // Sequencer: IDLE latches the request, FORMAT registers the write data,
  // WRITE/TRAP emit the one-cycle pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      off_q      <= '0;
      src_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
      trap_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wb.start) begin
            sel_q  <= wb.wb_sel;
            f3_q   <= wb.funct3;
            rd_q   <= wb.rd;
            off_q  <= wb.alu_out[1:0];
            case (wb.wb_sel)
              SEL_ALU:  src_q <= wb.alu_out;
              SEL_LOAD: src_q <= wb.mem_rdata;
              SEL_PC4:  src_q <= wb.pc_plus4;
              default:  src_q <= wb.imm;
            endcase
            busy_q  <= 1'b1;
            state_q <= S_FORMAT;
          end
        end
        S_FORMAT: begin
          rf_wdata_q <= fmt_d;
          rf_waddr_q <= rd_q;
          done_q     <= 1'b1;
`ifdef WB_MISALIGN_TRAP_EN
          if (misalign_d) begin
            trap_q  <= 1'b1;
            state_q <= S_TRAP;
          end else begin
            rf_we_q <= (rd_q != '0);
            state_q <= S_WRITE;
          end
`else
          rf_we_q    <= (rd_q != '0);
          state_q    <= S_WRITE;
`endif
        end
        S_WRITE: begin
          rf_we_q <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
`ifdef WB_MISALIGN_TRAP_EN
        S_TRAP: begin
          trap_q  <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
`endif
        default: begin
          rf_we_q <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign wb.rf_we    = rf_we_q;
  assign wb.rf_waddr = rf_waddr_q;
  assign wb.rf_wdata = rf_wdata_q;
  assign wb.busy     = busy_q;
  assign wb.done     = done_q;
`ifdef WB_MISALIGN_TRAP_EN
  assign wb.trap     = trap_q;
`endif

endmodule

// File: tb/tb_wb_result_writer.sv
// tb/tb_wb_result_writer.sv - self-checking bench for wb_result_writer (table vectors, corner sequences, random vs reference model)
module tb_wb_result_writer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_result_writer_if #(.XLEN(32), .RADDR_W(5)) bus ();

  wb_result_writer #(.XLEN(32), .RADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc;
    logic [31:0] imm;
  } op_t;

  typedef struct {
    logic        we;
    logic [31:0] wdata;
    logic        trap;
  } res_t;

  typedef struct {
    op_t  op;
    res_t exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Reference model: straight from the writeback rules, in plain arithmetic.
  function automatic res_t model(input op_t o);
    res_t        r;
    int          off;
    logic [31:0] b;
    logic [31:0] h;
    off     = int'(o.alu % 32'd4);
    r.trap  = 1'b0;
    r.wdata = 32'h0;
    case (o.sel)
      2'd0: r.wdata = o.alu;
      2'd2: r.wdata = o.pc;
      2'd3: r.wdata = o.imm;
      default: begin
        b = (o.mem >> (8 * off)) & 32'hFF;
        h = (o.mem >> (16 * (off / 2))) & 32'hFFFF;
        if (o.f3 == 3'd0)      r.wdata = (b >= 32'd128)   ? b + 32'hFFFFFF00 : b;
        else if (o.f3 == 3'd4) r.wdata = b;
        else if (o.f3 == 3'd1) r.wdata = (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
        else if (o.f3 == 3'd5) r.wdata = h;
        else                   r.wdata = o.mem;
`ifdef WB_MISALIGN_TRAP_EN
        if ((o.f3 == 3'd1 || o.f3 == 3'd5) && (off % 2 == 1)) r.trap = 1'b1;
        if (!(o.f3 == 3'd0 || o.f3 == 3'd4 || o.f3 == 3'd1 || o.f3 == 3'd5) && off != 0) r.trap = 1'b1;
`endif
      end
    endcase
    r.we = (o.rd != 5'd0) && !r.trap;
    return r;
  endfunction

  task automatic drive(input op_t o);
    bus.wb_sel    = o.sel;
    bus.funct3    = o.f3;
    bus.rd        = o.rd;
    bus.alu_out   = o.alu;
    bus.mem_rdata = o.mem;
    bus.pc_plus4  = o.pc;
    bus.imm       = o.imm;
  endtask

  // One full operation with cycle-exact checks: start sampled at edge N,
  // pulses visible during cycle N+2, idle again in cycle N+3.
  task automatic run_op(input op_t o, input res_t e, input string tag);
    @(negedge clk);
    drive(o);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check1({tag, ".busy_fmt"}, bus.busy, 1'b1);
    check1({tag, ".done_early"}, bus.done, 1'b0);
    check1({tag, ".we_early"}, bus.rf_we, 1'b0);
    @(negedge clk);
    check1({tag, ".done"}, bus.done, 1'b1);
    check1({tag, ".we"}, bus.rf_we, e.we);
`ifdef WB_MISALIGN_TRAP_EN
    check1({tag, ".trap"}, bus.trap, e.trap);
`endif
    if (!e.trap) begin
      check32({tag, ".wdata"}, bus.rf_wdata, e.wdata);
      check32({tag, ".waddr"}, {27'd0, bus.rf_waddr}, {27'd0, o.rd});
    end
    @(negedge clk);
    check1({tag, ".done_off"}, bus.done, 1'b0);
    check1({tag, ".we_off"}, bus.rf_we, 1'b0);
    check1({tag, ".busy_off"}, bus.busy, 1'b0);
`ifdef WB_MISALIGN_TRAP_EN
    check1({tag, ".trap_off"}, bus.trap, 1'b0);
`endif
    if (!e.trap) check32({tag, ".wdata_hold"}, bus.rf_wdata, e.wdata);
  endtask

  function automatic op_t mk(input logic [1:0] sel, input logic [2:0] f3, input logic [4:0] rd,
                             input logic [31:0] alu, input logic [31:0] mem,
                             input logic [31:0] pc, input logic [31:0] imm);
    op_t o;
    o.sel = sel; o.f3 = f3; o.rd = rd; o.alu = alu; o.mem = mem; o.pc = pc; o.imm = imm;
    return o;
  endfunction

  function automatic res_t mr(input logic we, input logic [31:0] wdata, input logic trap);
    res_t r;
    r.we = we; r.wdata = wdata; r.trap = trap;
    return r;
  endfunction

  vec_t tbl[10];

  initial begin
    op_t  o;
    res_t e;
    int   dones;
    logic [4:0] seen_addr;

    tbl[0] = '{mk(2'd0, 3'd0, 5'd5,  32'hDEADBEEF, 32'h0, 32'h0, 32'h0), mr(1'b1, 32'hDEADBEEF, 1'b0)};
    tbl[1] = '{mk(2'd1, 3'b000, 5'd1, 32'h3, 32'h80FF7F01, 32'h0, 32'h0), mr(1'b1, 32'hFFFFFF80, 1'b0)};
    tbl[2] = '{mk(2'd1, 3'b100, 5'd2, 32'h1, 32'h80FF7F01, 32'h0, 32'h0), mr(1'b1, 32'h0000007F, 1'b0)};
    tbl[3] = '{mk(2'd1, 3'b001, 5'd3, 32'h2, 32'h80FF7F01, 32'h0, 32'h0), mr(1'b1, 32'hFFFF80FF, 1'b0)};
    tbl[4] = '{mk(2'd1, 3'b101, 5'd4, 32'h0, 32'h80FF7F01, 32'h0, 32'h0), mr(1'b1, 32'h00007F01, 1'b0)};
    tbl[5] = '{mk(2'd1, 3'b010, 5'd6, 32'h0, 32'h80FF7F01, 32'h0, 32'h0), mr(1'b1, 32'h80FF7F01, 1'b0)};
    tbl[6] = '{mk(2'd2, 3'd0, 5'd0,  32'h0, 32'h0, 32'h104, 32'h0), mr(1'b0, 32'h104, 1'b0)};
    tbl[7] = '{mk(2'd3, 3'd0, 5'd31, 32'h0, 32'h0, 32'h0, 32'h12345000), mr(1'b1, 32'h12345000, 1'b0)};
`ifdef WB_MISALIGN_TRAP_EN
    tbl[8] = '{mk(2'd1, 3'b010, 5'd7, 32'h1002, 32'h80FF7F01, 32'h0, 32'h0), mr(1'b0, 32'h0, 1'b1)};
`else
    tbl[8] = '{mk(2'd1, 3'b010, 5'd7, 32'h1002, 32'h80FF7F01, 32'h0, 32'h0), mr(1'b1, 32'h80FF7F01, 1'b0)};
`endif
    tbl[9] = '{mk(2'd1, 3'b011, 5'd8, 32'h0, 32'hCAFEF00D, 32'h0, 32'h0), mr(1'b1, 32'hCAFEF00D, 1'b0)};

    bus.start = 1'b0;
    drive(mk(2'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check1("reset.we", bus.rf_we, 1'b0);
    check1("reset.done", bus.done, 1'b0);
    check1("reset.busy", bus.busy, 1'b0);
    check32("reset.wdata", bus.rf_wdata, 32'h0);
    check32("reset.waddr", {27'd0, bus.rf_waddr}, 32'h0);
    rst = 1'b1;

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].op, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Reset asserted while in FORMAT abandons the write
    @(negedge clk);
    drive(mk(2'd0, 3'd0, 5'd9, 32'h55AA55AA, 32'h0, 32'h0, 32'h0));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b0;
    #1;
    check1("rstmid.busy", bus.busy, 1'b0);
    check1("rstmid.done", bus.done, 1'b0);
    check32("rstmid.wdata", bus.rf_wdata, 32'h0);
    dones = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.rf_we || bus.done) dones++;
    end
    check32("rstmid.no_write", dones, 32'd0);
    rst = 1'b1;
    o = mk(2'd0, 3'd0, 5'd10, 32'h01234567, 32'h0, 32'h0, 32'h0);
    run_op(o, model(o), "after_rst");

    // Start pulsed during FORMAT and during WRITE is ignored
    @(negedge clk);
    drive(mk(2'd0, 3'd0, 5'd11, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0));
    bus.start = 1'b1;
    dones = 0;
    seen_addr = 5'd0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0 || c == 1) begin
        bus.start = 1'b1;
        bus.rd    = 5'd12;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        dones++;
        seen_addr = bus.rf_waddr;
      end
    end
    check32("busy_start.dones", dones, 32'd1);
    check32("busy_start.waddr", {27'd0, seen_addr}, 32'd11);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      o.sel = 2'($urandom_range(0, 3));
      o.f3  = 3'($urandom_range(0, 7));
      o.rd  = 5'($urandom_range(0, 31));
      o.alu = $urandom;
      o.mem = $urandom;
      o.pc  = $urandom;
      o.imm = $urandom;
      e = model(o);
      run_op(o, e, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
